dff_data_input: RTL and testbench

- Serial receiver for the DFF error-count stream.
- Samples one bit per `data_clk` and rebuilds the 10 × 12-bit error words, each sent LSB first with word 0 first.
- Publishes each complete 120-bit frame as a registered snapshot with a one-cycle valid strobe.
- Sits on the test-board side of the link, or in loopback on the FPGA, so the serializer can be checked against known counts.

---
 rtl/dff_data_input.sv | 206 ++++++++++++++++++++
 tb/tb_dff_data_input.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_data_input.sv
// Serial receiver for the DFF error-count stream: rebuilds NUM_WORDS x WORD_BITS frames sent LSB first.
// Optional build macro FRAME_DELTA_EN adds the words_changed flag against the previous committed frame.
module dff_data_input #(
    parameter int WORD_BITS = 12,
    parameter int NUM_WORDS = 10
) (
    input  logic                           data_clk,
    input  logic                           reset,
    input  logic                           data_in,
    input  logic                           frame_start,
    output logic [NUM_WORDS*WORD_BITS-1:0] rx_words,
    output logic                           frame_valid,
    output logic [15:0]                    frame_count,
    output logic                           sync_abort
`ifdef FRAME_DELTA_EN
    ,
    output logic                           words_changed
`endif
);

    localparam int FRAME_BITS = WORD_BITS * NUM_WORDS;
    localparam int BC_W       = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int WC_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [BC_W-1:0] BIT_ZERO  = BC_W'(0);
    localparam logic [BC_W-1:0] BIT_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_BITS - 1);
    localparam logic [WC_W-1:0] WORD_ZERO = WC_W'(0);
    localparam logic [WC_W-1:0] WORD_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [BC_W-1:0]      bit_cnt_r;
    logic [BC_W-1:0]      bit_next_s;
    logic [BC_W-1:0]      wr_idx_s;
    logic [WC_W-1:0]      word_cnt_r;
    logic [WC_W-1:0]      word_next_s;
    logic [WORD_BITS-1:0] cur_word_r;
    logic [WORD_BITS-1:0] last_word_s;
    logic [WORD_BITS-1:0] stage_r [NUM_WORDS];
    logic [FRAME_BITS-1:0] frame_s;
    logic [FRAME_BITS-1:0] rx_words_r;
    logic [15:0]          frame_count_r;
    logic                 frame_valid_r;
    logic                 sync_abort_r;
    logic                 take_s;
    logic                 restart_s;
    logic                 word_done_s;
    logic                 frame_done_s;
    logic                 abort_s;

    // State and position counters
    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= BIT_ZERO;
            word_cnt_r <= WORD_ZERO;
        end else begin
            state_r    <= state_next_s;
            bit_cnt_r  <= bit_next_s;
            word_cnt_r <= word_next_s;
        end
    end

    // Next-state decode: completion wins over resync so a frame_start on the last bit still commits
    always_comb begin
        state_next_s = state_r;
        bit_next_s   = bit_cnt_r;
        word_next_s  = word_cnt_r;
        take_s       = 1'b0;
        restart_s    = 1'b0;
        word_done_s  = 1'b0;
        frame_done_s = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next_s = ST_RECV;
                    take_s       = 1'b1;
                    restart_s    = 1'b1;
                    bit_next_s   = BIT_ONE;
                    word_next_s  = WORD_ZERO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                take_s = 1'b1;
                if ((bit_cnt_r == BIT_LAST) && (word_cnt_r == WORD_LAST)) begin
                    frame_done_s = 1'b1;
                    word_next_s  = WORD_ZERO;
                    if (frame_start) begin
                        restart_s  = 1'b1;
                        bit_next_s = BIT_ONE;
                    end else begin
                        bit_next_s = BIT_ZERO;
                    end
                end else if (frame_start && ((bit_cnt_r != BIT_ZERO) || (word_cnt_r != WORD_ZERO))) begin
                    abort_s     = 1'b1;
                    restart_s   = 1'b1;
                    bit_next_s  = BIT_ONE;
                    word_next_s = WORD_ZERO;
                end else if (bit_cnt_r == BIT_LAST) begin
                    word_done_s = 1'b1;
                    bit_next_s  = BIT_ZERO;
                    word_next_s = word_cnt_r + WORD_ONE;
                end else begin
                    bit_next_s = bit_cnt_r + BIT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                bit_next_s   = BIT_ZERO;
                word_next_s  = WORD_ZERO;
            end
        endcase
    end

    // A restart stores the current bit as bit 0 regardless of where the counter was
    always_comb begin
        if (restart_s) begin
            wr_idx_s = BIT_ZERO;
        end else begin
            wr_idx_s = bit_cnt_r;
        end
    end

    // Word being closed this cycle, including the bit on the wire
    always_comb begin
        last_word_s           = cur_word_r;
        last_word_s[BIT_LAST] = data_in;
    end

    // Full frame image: staged words plus the word closing this cycle in the top slot
    always_comb begin
        frame_s = {FRAME_BITS{1'b0}};
        for (int i = 0; i < NUM_WORDS - 1; i++) begin
            frame_s[i*WORD_BITS +: WORD_BITS] = stage_r[i];
        end
        frame_s[(NUM_WORDS-1)*WORD_BITS +: WORD_BITS] = last_word_s;
    end

    // Bit capture, word staging and frame commit
    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            cur_word_r    <= {WORD_BITS{1'b0}};
            for (int i = 0; i < NUM_WORDS; i++) begin
                stage_r[i] <= {WORD_BITS{1'b0}};
            end
            rx_words_r    <= {FRAME_BITS{1'b0}};
            frame_count_r <= 16'd0;
            frame_valid_r <= 1'b0;
            sync_abort_r  <= 1'b0;
        end else begin
            if (take_s) begin
                cur_word_r[wr_idx_s] <= data_in;
            end
            if (word_done_s) begin
                stage_r[word_cnt_r] <= last_word_s;
            end
            if (frame_done_s) begin
                rx_words_r    <= frame_s;
                frame_count_r <= frame_count_r + 16'd1;
            end
            frame_valid_r <= frame_done_s;
            sync_abort_r  <= abort_s;
        end
    end

    assign rx_words    = rx_words_r;
    assign frame_valid = frame_valid_r;
    assign frame_count = frame_count_r;
    assign sync_abort  = sync_abort_r;

`ifdef FRAME_DELTA_EN
    logic words_changed_r;

    function automatic logic frame_differs(input logic [FRAME_BITS-1:0] a,
                                           input logic [FRAME_BITS-1:0] b);
        logic diff;
        diff = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            diff = diff | (a[i*WORD_BITS +: WORD_BITS] != b[i*WORD_BITS +: WORD_BITS]);
        end
        return diff;
    endfunction

    // rx_words_r still holds the previous committed frame when the new one completes
    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            words_changed_r <= 1'b0;
        end else if (frame_done_s) begin
            words_changed_r <= frame_differs(frame_s, rx_words_r);
        end
    end

    assign words_changed = words_changed_r;
`endif

endmodule

// File: tb/tb_dff_data_input.sv
// Self-checking bench for dff_data_input: directed scenarios plus a randomized stream
// compared against a bit-position model of the frame receiver.
module tb_dff_data_input;

    localparam int WB = 12;
    localparam int NW = 10;
    localparam int FB = WB * NW;
    localparam logic [FB-1:0] FS_FIRST = 120'd1;
    localparam logic [FB-1:0] FS_NONE  = 120'd0;

    logic          data_clk = 1'b0;
    logic          reset;
    logic          data_in;
    logic          frame_start;
    logic [FB-1:0] rx_words;
    logic          frame_valid;
    logic [15:0]   frame_count;
    logic          sync_abort;
`ifdef FRAME_DELTA_EN
    logic          words_changed;
`endif

    dff_data_input #(.WORD_BITS(WB), .NUM_WORDS(NW)) dut (
        .data_clk    (data_clk),
        .reset       (reset),
        .data_in     (data_in),
        .frame_start (frame_start),
        .rx_words    (rx_words),
        .frame_valid (frame_valid),
        .frame_count (frame_count),
        .sync_abort  (sync_abort)
`ifdef FRAME_DELTA_EN
        ,
        .words_changed (words_changed)
`endif
    );

    always #5 data_clk = ~data_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model: idle flag, position 0..119 within the frame, accumulator
    logic          m_idle;
    int            m_pos;
    logic [FB-1:0] m_acc;
    logic [FB-1:0] m_rx;
    int            m_count;
    logic          m_valid;
    logic          m_abort;

    int            dut_v_q[$];
    int            mdl_v_q[$];
    int            dut_a_q[$];
    int            mdl_a_q[$];
    logic [FB-1:0] dut_rx_q[$];
    logic [FB-1:0] mdl_rx_q[$];
    logic          dut_wc_q[$];

    task automatic clear_logs();
        dut_v_q.delete();  mdl_v_q.delete();
        dut_a_q.delete();  mdl_a_q.delete();
        dut_rx_q.delete(); mdl_rx_q.delete();
        dut_wc_q.delete();
    endtask

    task automatic model_reset();
        m_idle  = 1'b1;
        m_pos   = 0;
        m_acc   = '0;
        m_rx    = '0;
        m_count = 0;
        m_valid = 1'b0;
        m_abort = 1'b0;
    endtask

    task automatic model_step(input logic d, input logic fs);
        m_valid = 1'b0;
        m_abort = 1'b0;
        if (m_idle) begin
            if (fs) begin
                m_idle   = 1'b0;
                m_acc[0] = d;
                m_pos    = 1;
            end
        end else if (m_pos == FB - 1) begin
            m_acc[FB-1] = d;
            m_rx        = m_acc;
            m_valid     = 1'b1;
            m_count     = (m_count + 1) % 65536;
            if (fs) begin
                m_acc[0] = d;
                m_pos    = 1;
            end else begin
                m_pos = 0;
            end
        end else if (fs && m_pos != 0) begin
            m_abort  = 1'b1;
            m_acc[0] = d;
            m_pos    = 1;
        end else begin
            m_acc[m_pos] = d;
            m_pos        = m_pos + 1;
        end
    endtask

    task automatic tick(input logic d, input logic fs);
        data_in     = d;
        frame_start = fs;
        @(posedge data_clk);
        #1;
        cyc++;
        model_step(d, fs);
        if (frame_valid === 1'b1) begin
            dut_v_q.push_back(cyc);
            dut_rx_q.push_back(rx_words);
`ifdef FRAME_DELTA_EN
            dut_wc_q.push_back(words_changed);
`endif
        end
        if (sync_abort === 1'b1) dut_a_q.push_back(cyc);
        if (m_valid) begin
            mdl_v_q.push_back(cyc);
            mdl_rx_q.push_back(m_rx);
        end
        if (m_abort) mdl_a_q.push_back(cyc);
    endtask

    task automatic send_bits(input logic [FB-1:0] f, input logic [FB-1:0] fsm,
                             input int lo, input int hi);
        for (int k = lo; k <= hi; k++) tick(f[k], fsm[k]);
    endtask

    function automatic logic [FB-1:0] rand_frame();
        logic [FB-1:0] f;
        for (int i = 0; i < NW; i++) f[i*WB +: WB] = 12'($urandom);
        return f;
    endfunction

    task automatic apply_reset();
        data_in     = 1'b0;
        frame_start = 1'b0;
        reset       = 1'b1;
        @(posedge data_clk);
        #1;
        reset = 1'b0;
        model_reset();
        clear_logs();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        data_in     = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(posedge data_clk);
        #1;
        n_checks++; if (rx_words !== '0) begin n_fail++; $display("FAIL reset_rx: got %h required 0", rx_words); end
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", frame_valid); end
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", frame_count); end
        n_checks++; if (sync_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b required 0", sync_abort); end
`ifdef FRAME_DELTA_EN
        n_checks++; if (words_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b required 0", words_changed); end
`endif
        reset = 1'b0;
        model_reset();
        clear_logs();
    endtask

    task automatic test_basic();
        logic [FB-1:0] f;
        int s;
        apply_reset();
        for (int i = 0; i < NW; i++) f[i*WB +: WB] = 12'(i + 1);
        s = cyc;
        send_bits(f, FS_FIRST, 0, FB - 1);
        n_checks++; if (dut_v_q.size() != 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d pulses required 1", dut_v_q.size()); end
        else begin
            n_checks++; if (dut_v_q[0] != s + 120) begin n_fail++; $display("FAIL basic_latency: got cycle %0d required %0d", dut_v_q[0] - s, 120); end
        end
        n_checks++; if (rx_words[3*WB +: WB] !== 12'h004) begin n_fail++; $display("FAIL basic_word3: got %h required 004", rx_words[3*WB +: WB]); end
        n_checks++; if (rx_words !== f) begin n_fail++; $display("FAIL basic_frame: got %h required %h", rx_words, f); end
        n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d required 1", frame_count); end
        tick(1'b0, 1'b0);
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b required 0", frame_valid); end
        n_checks++; if (dut_a_q.size() != 0) begin n_fail++; $display("FAIL basic_abort: got %0d pulses required 0", dut_a_q.size()); end
    endtask

    task automatic test_free_running();
        logic [FB-1:0] f;
        int s;
        apply_reset();
        f = rand_frame();
        s = cyc;
        send_bits(f, FS_FIRST, 0, FB - 1);
        send_bits(f, FS_NONE, 0, FB - 1);
        send_bits(f, FS_NONE, 0, FB - 1);
        n_checks++; if (dut_v_q.size() != 3) begin n_fail++; $display("FAIL loop_valid_count: got %0d required 3", dut_v_q.size()); end
        for (int k = 0; k < dut_v_q.size() && k < 3; k++) begin
            n_checks++; if (dut_v_q[k] != s + 120 * (k + 1)) begin n_fail++; $display("FAIL loop_timing: pulse %0d at %0d required %0d", k, dut_v_q[k] - s, 120 * (k + 1)); end
        end
        n_checks++; if (frame_count !== 16'd3) begin n_fail++; $display("FAIL loop_count: got %0d required 3", frame_count); end
        n_checks++; if (dut_a_q.size() != 0) begin n_fail++; $display("FAIL loop_abort: got %0d pulses required 0", dut_a_q.size()); end
        n_checks++; if (rx_words !== f) begin n_fail++; $display("FAIL loop_frame: got %h required %h", rx_words, f); end
    endtask

    task automatic test_resync();
        logic [FB-1:0] g;
        logic [FB-1:0] ones;
        int s;
        apply_reset();
        g    = rand_frame();
        ones = {FB{1'b1}};
        s    = cyc;
        send_bits(g, FS_FIRST, 0, 49);
        send_bits(ones, FS_FIRST, 0, FB - 1);
        n_checks++; if (dut_a_q.size() != 1) begin n_fail++; $display("FAIL resync_abort_count: got %0d required 1", dut_a_q.size()); end
        else begin
            n_checks++; if (dut_a_q[0] != s + 51) begin n_fail++; $display("FAIL resync_abort_pos: got bit %0d required 50", dut_a_q[0] - s - 1); end
        end
        n_checks++; if (dut_v_q.size() != 1) begin n_fail++; $display("FAIL resync_valid_count: got %0d required 1", dut_v_q.size()); end
        n_checks++; if (rx_words !== ones) begin n_fail++; $display("FAIL resync_frame: got %h required all ones", rx_words); end
        n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL resync_count: got %0d required 1", frame_count); end
    endtask

    task automatic test_reset_mid();
        logic [FB-1:0] f;
        logic [FB-1:0] g;
        apply_reset();
        f    = rand_frame();
        f[0] = 1'b1;
        send_bits(f, FS_FIRST, 0, FB - 1);
        g = rand_frame();
        send_bits(g, FS_FIRST, 0, 69);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (rx_words !== '0) begin n_fail++; $display("FAIL midreset_rx: got %h required 0", rx_words); end
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL midreset_count: got %0d required 0", frame_count); end
        n_checks++; if (frame_valid !== 1'b0 || sync_abort !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses: got valid=%b abort=%b required 0/0", frame_valid, sync_abort); end
        #2;
        reset = 1'b0;
        model_reset();
        clear_logs();
        for (int k = 0; k < 2 * FB; k++) tick(1'($urandom), 1'b0);
        n_checks++; if (dut_v_q.size() != 0) begin n_fail++; $display("FAIL midreset_idle_valid: got %0d pulses required 0", dut_v_q.size()); end
        n_checks++; if (dut_a_q.size() != 0) begin n_fail++; $display("FAIL midreset_idle_abort: got %0d pulses required 0", dut_a_q.size()); end
        n_checks++; if (frame_count !== 16'd0 || rx_words !== '0) begin n_fail++; $display("FAIL midreset_idle_state: got count=%0d rx=%h required 0", frame_count, rx_words); end
    endtask

    task automatic test_boundary();
        logic [FB-1:0] a;
        logic [FB-1:0] b;
        logic [FB-1:0] fsm;
        int s;
        apply_reset();
        b = rand_frame();
        b[9*WB +: WB] = 12'hABC;
        a = rand_frame();
        a[FB-1] = b[0];
        fsm = FS_FIRST;
        fsm[FB-1] = 1'b1;
        s = cyc;
        send_bits(a, fsm, 0, FB - 1);
        send_bits(b, FS_NONE, 1, FB - 1);
        n_checks++; if (dut_v_q.size() != 2) begin n_fail++; $display("FAIL boundary_valid_count: got %0d required 2", dut_v_q.size()); end
        else begin
            n_checks++; if (dut_v_q[0] != s + 120 || dut_v_q[1] != s + 239) begin n_fail++; $display("FAIL boundary_timing: got %0d,%0d required 120,239", dut_v_q[0] - s, dut_v_q[1] - s); end
            n_checks++; if (dut_rx_q[0] !== a) begin n_fail++; $display("FAIL boundary_first: got %h required %h", dut_rx_q[0], a); end
        end
        n_checks++; if (dut_a_q.size() != 0) begin n_fail++; $display("FAIL boundary_abort: got %0d pulses required 0", dut_a_q.size()); end
        n_checks++; if (rx_words[9*WB +: WB] !== 12'hABC) begin n_fail++; $display("FAIL boundary_word9: got %h required abc", rx_words[9*WB +: WB]); end
        n_checks++; if (rx_words !== b) begin n_fail++; $display("FAIL boundary_second: got %h required %h", rx_words, b); end
        n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL boundary_count: got %0d required 2", frame_count); end
    endtask

    task automatic test_random();
        apply_reset();
        tick(1'($urandom), 1'b1);
        for (int k = 0; k < 3000; k++) tick(1'($urandom), ($urandom_range(0, 199) == 0));
        n_checks++; if (dut_v_q.size() != mdl_v_q.size()) begin n_fail++; $display("FAIL rand_valid_count: got %0d required %0d", dut_v_q.size(), mdl_v_q.size()); end
        for (int k = 0; k < dut_v_q.size() && k < mdl_v_q.size(); k++) begin
            n_checks++; if (dut_v_q[k] != mdl_v_q[k] || dut_rx_q[k] !== mdl_rx_q[k]) begin n_fail++; $display("FAIL rand_frame_%0d: got cycle %0d rx %h required cycle %0d rx %h", k, dut_v_q[k], dut_rx_q[k], mdl_v_q[k], mdl_rx_q[k]); end
        end
        n_checks++; if (dut_a_q.size() != mdl_a_q.size()) begin n_fail++; $display("FAIL rand_abort_count: got %0d required %0d", dut_a_q.size(), mdl_a_q.size()); end
        for (int k = 0; k < dut_a_q.size() && k < mdl_a_q.size(); k++) begin
            n_checks++; if (dut_a_q[k] != mdl_a_q[k]) begin n_fail++; $display("FAIL rand_abort_%0d: got cycle %0d required %0d", k, dut_a_q[k], mdl_a_q[k]); end
        end
        n_checks++; if (frame_count !== 16'(m_count)) begin n_fail++; $display("FAIL rand_count: got %0d required %0d", frame_count, m_count); end
        n_checks++; if (rx_words !== m_rx) begin n_fail++; $display("FAIL rand_rx: got %h required %h", rx_words, m_rx); end
    endtask

`ifdef FRAME_DELTA_EN
    task automatic test_delta();
        logic [FB-1:0] a;
        logic [FB-1:0] b;
        logic          exp_wc [3];
        apply_reset();
        a    = rand_frame();
        a[0] = 1'b1;
        b    = a;
        b[7*WB + 11] = ~a[7*WB + 11];
        exp_wc[0] = 1'b1;
        exp_wc[1] = 1'b0;
        exp_wc[2] = 1'b1;
        send_bits(a, FS_FIRST, 0, FB - 1);
        send_bits(a, FS_NONE, 0, FB - 1);
        send_bits(b, FS_NONE, 0, FB - 1);
        n_checks++; if (dut_wc_q.size() != 3) begin n_fail++; $display("FAIL delta_count: got %0d required 3", dut_wc_q.size()); end
        for (int k = 0; k < dut_wc_q.size() && k < 3; k++) begin
            n_checks++; if (dut_wc_q[k] !== exp_wc[k]) begin n_fail++; $display("FAIL delta_flag_%0d: got %b required %b", k, dut_wc_q[k], exp_wc[k]); end
        end
        tick(1'b0, 1'b0);
        n_checks++; if (words_changed !== 1'b1) begin n_fail++; $display("FAIL delta_hold: got %b required 1", words_changed); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_free_running();
        test_resync();
        test_reset_mid();
        test_boundary();
        test_random();
`ifdef FRAME_DELTA_EN
        test_delta();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
